tree_node_loader: RTL and testbench

- Writer side of the tree node memory that the scheduler reads: the 222-bit node words, node 0 = root, are read at child indices.
- Receives a byte stream from the host over in_valid/in_ready.
- Assembles full node words and writes them sequentially into node memory from address 0.
- Validates the frame with a node count and XOR checksum, then raises tree_ready so the scheduler may leave reset and start.

---
 rtl/tree_node_loader_pkg.sv | 23 ++
 rtl/tree_node_loader_if.sv | 33 +++
 rtl/tree_node_loader_node_assembler.sv | 40 ++++
 rtl/tree_node_loader.sv | 174 +++++++++++++++++
 tb/tb_tree_node_loader.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tree_node_loader_pkg.sv
// Shared tree-memory constants used by the loader, the scheduler and the PE blocks.
//   NODE_W     : node word width in bits
//   ADDR_W     : node memory address width
//   CNT_W      : width of node counts (holds DEPTH itself)
//   DEPTH      : largest node count a frame may declare
//   SYNC_BYTE  : frame start marker
//   NODE_BYTES : stream bytes per node word
package tree_pkg;

  localparam int unsigned NODE_W     = 222;
  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned CNT_W      = ADDR_W + 1;
  localparam int unsigned DEPTH      = 1024;
  localparam logic [7:0]  SYNC_BYTE  = 8'hA5;
  localparam int unsigned NODE_BYTES = (NODE_W + 7) / 8;
  localparam int unsigned IDX_W      = $clog2(NODE_BYTES);

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_HDR   = 2'd1;
  localparam logic [1:0] ERR_COUNT = 2'd2;
  localparam logic [1:0] ERR_CSUM  = 2'd3;

endpackage

// File: rtl/tree_node_loader_if.sv
// Host byte stream plus node-memory write port of the tree loader.
//   in_data/in_valid/in_ready : byte stream, handshake = in_valid & in_ready
//   mem_we/mem_addr/mem_wdata : one-cycle node write strobe, address and word
// master = host/memory side, slave = loader.
interface tree_node_loader_if;
  import tree_pkg::*;

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [NODE_W-1:0] mem_wdata;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

endinterface

// File: rtl/tree_node_loader_node_assembler.sv
// Collects NODE_BYTES stream bytes MSB first into one node word.
//   clk, reset : clock, asynchronous active-high reset
//   restart    : synchronous return to byte 0 with an empty shift register
//   data_byte  : incoming stream byte
//   accept     : data_byte is consumed this cycle
//   word       : assembled word including the current byte (valid with word_done)
//   word_done  : the byte accepted this cycle completes the node
module node_assembler
  import tree_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic [7:0]        data_byte,
  input  logic              accept,
  output logic [NODE_W-1:0] word,
  output logic              word_done
);

  logic [NODE_W-9:0] shift_q;
  logic [IDX_W-1:0]  idx_q;

  // Only NODE_W-8 bits are kept; the bits of the first byte above NODE_W fall off the top.
  assign word      = {shift_q, data_byte};
  assign word_done = accept && (idx_q == IDX_W'(NODE_BYTES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else if (restart) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else if (accept) begin
      shift_q <= word[NODE_W-9:0];
      idx_q   <= word_done ? '0 : idx_q + IDX_W'(1);
    end
  end

endmodule

// File: rtl/tree_node_loader.sv
// Writer side of the tree node memory. Parses a framed byte stream
// (SYNC, count hi, count lo, count x NODE_BYTES node bytes, XOR checksum),
// writes node words from address 0 and flags a verified tree.
//   clk, reset   : clock, asynchronous active-high reset
//   bus          : stream in / memory write out (slave modport)
//   clear        : synchronous abort/acknowledge, back to idle
//   tree_ready   : complete, checksum-verified tree in memory
//   error        : frame rejected, err_code gives the reason
//   nodes_loaded : nodes written in the current frame
module tree_node_loader
  import tree_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  tree_node_loader_if.slave    bus,
  input  logic                 clear,
  output logic                 tree_ready,
  output logic                 error,
  output logic [1:0]           err_code,
  output logic [CNT_W-1:0]     nodes_loaded
);

  typedef enum logic [2:0] {
    StIdle, StHdrHi, StHdrLo, StNode, StWrite, StCsum, StDone, StErr
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        csum_q, csum_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  nodes_q, nodes_d;
  logic [1:0]        err_q, err_d;
  logic [ADDR_W-1:0] addr_q;
  logic [NODE_W-1:0] wdata_q;

  logic              in_ready;
  logic              hs;
  logic              asm_accept;
  logic              asm_restart;
  logic [NODE_W-1:0] asm_word;
  logic              asm_done;
  logic [CNT_W-1:0]  count_v;
  logic [CNT_W-1:0]  nodes_inc;

  // in_ready is gated by reset so the host sees no acceptance while reset is held.
  assign in_ready = ~reset & ((state_q == StIdle) | (state_q == StHdrHi) |
                              (state_q == StHdrLo) | (state_q == StNode) |
                              (state_q == StCsum));
  // clear wins over a coinciding handshake: the byte is dropped.
  assign hs          = bus.in_valid & in_ready & ~clear;
  assign asm_accept  = hs & (state_q == StNode);
  assign asm_restart = clear | (state_q == StIdle);
  assign count_v     = {count_q[CNT_W-1:8], bus.in_data};
  assign nodes_inc   = nodes_q + CNT_W'(1);

  node_assembler u_node_assembler (
    .clk       (clk),
    .reset     (reset),
    .restart   (asm_restart),
    .data_byte (bus.in_data),
    .accept    (asm_accept),
    .word      (asm_word),
    .word_done (asm_done)
  );

  always_comb begin
    state_d = state_q;
    csum_d  = csum_q;
    count_d = count_q;
    nodes_d = nodes_q;
    err_d   = err_q;
    if (clear) begin
      state_d = StIdle;
      nodes_d = '0;
      err_d   = ERR_NONE;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (hs && (bus.in_data == SYNC_BYTE)) begin
            state_d = StHdrHi;
            csum_d  = '0;
          end
        end
        StHdrHi: begin
          if (hs) begin
            csum_d = csum_q ^ bus.in_data;
            // Count is CNT_W bits wide so that DEPTH itself is representable.
            if (bus.in_data[7:CNT_W-8] != '0) begin
              state_d = StErr;
              err_d   = ERR_HDR;
            end else begin
              count_d = {bus.in_data[CNT_W-9:0], 8'h00};
              state_d = StHdrLo;
            end
          end
        end
        StHdrLo: begin
          if (hs) begin
            csum_d  = csum_q ^ bus.in_data;
            count_d = count_v;
            if (count_v == '0) begin
              state_d = StErr;
              err_d   = ERR_HDR;
            end else if (count_v > CNT_W'(DEPTH)) begin
              state_d = StErr;
              err_d   = ERR_COUNT;
            end else begin
              state_d = StNode;
            end
          end
        end
        StNode: begin
          if (hs) begin
            csum_d = csum_q ^ bus.in_data;
            if (asm_done) state_d = StWrite;
          end
        end
        StWrite: begin
          nodes_d = nodes_inc;
          state_d = (nodes_inc < count_q) ? StNode : StCsum;
        end
        StCsum: begin
          if (hs) begin
            if (bus.in_data == csum_q) begin
              state_d = StDone;
            end else begin
              state_d = StErr;
              err_d   = ERR_CSUM;
            end
          end
        end
        StDone:  state_d = StDone;
        StErr:   state_d = StErr;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      csum_q  <= '0;
      count_q <= '0;
      nodes_q <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      csum_q  <= csum_d;
      count_q <= count_d;
      nodes_q <= nodes_d;
      err_q   <= err_d;
    end
  end

  // Address and word are captured with the last node byte and held until the next node completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (asm_done) begin
      addr_q  <= nodes_q[ADDR_W-1:0];
      wdata_q <= asm_word;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = (state_q == StWrite) & ~clear;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign tree_ready    = (state_q == StDone);
  assign error         = (state_q == StErr);
  assign err_code      = err_q;
  assign nodes_loaded  = nodes_q;

endmodule

// File: tb/tb_tree_node_loader.sv
module tb_tree_node_loader;
  import tree_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;
  logic tree_ready;
  logic error;
  logic [1:0] err_code;
  logic [CNT_W-1:0] nodes_loaded;

  tree_node_loader_if bus ();

  tree_node_loader dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .clear        (clear),
    .tree_ready   (tree_ready),
    .error        (error),
    .err_code     (err_code),
    .nodes_loaded (nodes_loaded)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass = 0;
  int cyc = 0;
  int last_hs = -100;
  bit gap_en = 1'b0;

  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [NODE_W-1:0] wr_data_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [NODE_W-1:0] exp_data_q[$];

  typedef struct {
    logic [7:0] hi;
    logic [7:0] lo;
    bit         send_lo;
    bit         exp_err;
    logic [1:0] exp_code;
  } hdr_vec_t;

  hdr_vec_t hv[5];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clk) cyc++;

  // Write monitor: records every strobe and checks in_ready and latency in the WRITE cycle.
  always @(negedge clk) begin
    if (bus.in_valid && bus.in_ready && !clear) last_hs = cyc;
    if (bus.mem_we) begin
      wr_addr_q.push_back(bus.mem_addr);
      wr_data_q.push_back(bus.mem_wdata);
      check("in_ready_in_write", 256'(bus.in_ready), 256'(0));
      check("write_latency", 256'(cyc - last_hs), 256'(1));
    end
  end

  function automatic logic [7:0] node_byte(input int n, input int i);
    return 8'(n * 28 + i + 1);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n;
    if (gap_en) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) check("in_ready_timeout", 256'(bus.in_ready), 256'(1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Sends a node's bytes and queues the expected write.
  task automatic send_node(input int id, input int addr, inout logic [7:0] cs);
    logic [223:0] w;
    w = '0;
    for (int i = 0; i < 28; i++) begin
      send_byte(node_byte(id, i));
      cs = cs ^ node_byte(id, i);
      w = {w[215:0], node_byte(id, i)};
    end
    exp_addr_q.push_back(ADDR_W'(addr));
    exp_data_q.push_back(w[NODE_W-1:0]);
  endtask

  task automatic send_frame(input int cnt, input int first_id, input bit bad_csum);
    logic [7:0] cs;
    logic [7:0] hi;
    logic [7:0] lo;
    hi = 8'(cnt >> 8);
    lo = 8'(cnt);
    cs = hi ^ lo;
    send_byte(SYNC_BYTE);
    send_byte(hi);
    send_byte(lo);
    for (int n = 0; n < cnt; n++) send_node(first_id + n, n, cs);
    send_byte(bad_csum ? ~cs : cs);
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_write_count"}, 256'(wr_addr_q.size()), 256'(exp_addr_q.size()));
    for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
      check({tag, "_addr"}, 256'(wr_addr_q[i]), 256'(exp_addr_q[i]));
      check({tag, "_data"}, 256'(wr_data_q[i]), 256'(exp_data_q[i]));
    end
    wr_addr_q.delete();
    wr_data_q.delete();
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] cs;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;

    hv[0] = '{hi: 8'h04, lo: 8'h01, send_lo: 1'b1, exp_err: 1'b1, exp_code: 2'd2};
    hv[1] = '{hi: 8'h00, lo: 8'h00, send_lo: 1'b1, exp_err: 1'b1, exp_code: 2'd1};
    hv[2] = '{hi: 8'h80, lo: 8'h00, send_lo: 1'b0, exp_err: 1'b1, exp_code: 2'd1};
    hv[3] = '{hi: 8'h07, lo: 8'hFF, send_lo: 1'b1, exp_err: 1'b1, exp_code: 2'd2};
    hv[4] = '{hi: 8'h04, lo: 8'h00, send_lo: 1'b1, exp_err: 1'b0, exp_code: 2'd0};

    // Reset state
    #12;
    check("rst_in_ready", 256'(bus.in_ready), 256'(0));
    check("rst_mem_we", 256'(bus.mem_we), 256'(0));
    check("rst_tree_ready", 256'(tree_ready), 256'(0));
    check("rst_error", 256'(error), 256'(0));
    check("rst_err_code", 256'(err_code), 256'(0));
    check("rst_nodes", 256'(nodes_loaded), 256'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("idle_in_ready", 256'(bus.in_ready), 256'(1));

    // Single-node frame
    send_frame(1, 0, 1'b0);
    check("t1_tree_ready", 256'(tree_ready), 256'(1));
    check("t1_nodes", 256'(nodes_loaded), 256'(1));
    check("t1_error", 256'(error), 256'(0));
    check("t1_done_in_ready", 256'(bus.in_ready), 256'(0));
    compare_writes("t1");
    pulse_clear();
    check("t1_clr_tree_ready", 256'(tree_ready), 256'(0));
    check("t1_clr_nodes", 256'(nodes_loaded), 256'(0));

    // Garbage then a 3-node frame with valid gaps
    send_byte(8'h00);
    send_byte(8'h33);
    gap_en = 1'b1;
    send_frame(3, 5, 1'b0);
    gap_en = 1'b0;
    check("t2_tree_ready", 256'(tree_ready), 256'(1));
    check("t2_nodes", 256'(nodes_loaded), 256'(3));
    compare_writes("t2");
    pulse_clear();

    // Header vectors
    for (int k = 0; k < 5; k++) begin
      send_byte(SYNC_BYTE);
      send_byte(hv[k].hi);
      if (hv[k].send_lo) send_byte(hv[k].lo);
      @(negedge clk);
      check($sformatf("hdr%0d_error", k), 256'(error), 256'(hv[k].exp_err));
      check($sformatf("hdr%0d_code", k), 256'(err_code), 256'(hv[k].exp_code));
      check($sformatf("hdr%0d_in_ready", k), 256'(bus.in_ready), 256'(!hv[k].exp_err));
      check($sformatf("hdr%0d_no_write", k), 256'(wr_addr_q.size()), 256'(0));
      @(posedge clk);
      #1;
      pulse_clear();
      check($sformatf("hdr%0d_clr_error", k), 256'(error), 256'(0));
      check($sformatf("hdr%0d_clr_code", k), 256'(err_code), 256'(0));
    end

    // Bad checksum on a 2-node frame
    send_frame(2, 9, 1'b1);
    check("t4_error", 256'(error), 256'(1));
    check("t4_code", 256'(err_code), 256'(3));
    check("t4_tree_ready", 256'(tree_ready), 256'(0));
    compare_writes("t4");
    pulse_clear();

    // Reset partway into node 1 of a 2-node frame
    cs = 8'h00 ^ 8'h02;
    send_byte(SYNC_BYTE);
    send_byte(8'h00);
    send_byte(8'h02);
    send_node(20, 0, cs);
    for (int i = 0; i < 10; i++) send_byte(node_byte(21, i));
    reset = 1'b1;
    #1;
    check("t6_rst_in_ready", 256'(bus.in_ready), 256'(0));
    check("t6_rst_mem_we", 256'(bus.mem_we), 256'(0));
    check("t6_rst_nodes", 256'(nodes_loaded), 256'(0));
    check("t6_rst_tree_ready", 256'(tree_ready), 256'(0));
    check("t6_rst_error", 256'(error), 256'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    compare_writes("t6a");
    send_frame(1, 30, 1'b0);
    check("t6_tree_ready", 256'(tree_ready), 256'(1));
    check("t6_nodes", 256'(nodes_loaded), 256'(1));
    compare_writes("t6b");
    pulse_clear();

    // clear during the WRITE cycle
    send_byte(SYNC_BYTE);
    send_byte(8'h00);
    send_byte(8'h01);
    for (int i = 0; i < 28; i++) send_byte(node_byte(40, i));
    pulse_clear();
    check("t6c_no_write", 256'(wr_addr_q.size()), 256'(0));
    check("t6c_nodes", 256'(nodes_loaded), 256'(0));
    check("t6c_in_ready", 256'(bus.in_ready), 256'(1));
    check("t6c_tree_ready", 256'(tree_ready), 256'(0));
    repeat (3) @(posedge clk);
    #1;
    check("t6c_still_no_write", 256'(wr_addr_q.size()), 256'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
